noc_vchannel_mux: RTL and testbench

Packet-atomic virtual-channel multiplexer sitting directly upstream of the 2D mesh node input port. It merges `CHANNELS` per-channel flit streams from a network adapter onto one physical link, one flit per cycle. Arbitration is round-robin with a registered output stage. Each flit carries a one-hot channel-valid that drives a node's `in_flit`/`in_last`/`in_valid`/`in_ready` channel slices.

---
 rtl/noc_vchannel_mux_if.sv | 24 ++
 rtl/noc_vchannel_mux.sv | 111 +++++++++++
 tb/tb_noc_vchannel_mux.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_vchannel_mux_if.sv
// Handshake bundle between the network adapter, the VC mux and the mesh node input port.
interface noc_vchannel_mux_if #(
  parameter int FLIT_WIDTH = 32,
  parameter int CHANNELS   = 7
);
  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] in_flit;
  logic [CHANNELS-1:0]                 in_last;
  logic [CHANNELS-1:0]                 in_valid;
  logic [CHANNELS-1:0]                 in_ready;
  logic [FLIT_WIDTH-1:0]               out_flit;
  logic                                out_last;
  logic [CHANNELS-1:0]                 out_valid;
  logic [CHANNELS-1:0]                 out_ready;

  modport master (
    output in_flit, in_last, in_valid, out_ready,
    input  in_ready, out_flit, out_last, out_valid
  );

  modport slave (
    input  in_flit, in_last, in_valid, out_ready,
    output in_ready, out_flit, out_last, out_valid
  );
endinterface

// File: rtl/noc_vchannel_mux.sv
// Packet-atomic round-robin VC mux: merges CHANNELS flit streams onto one link through a
// single registered holding stage; a packet owns the link from head flit to last flit.
module noc_vchannel_mux #(
  parameter int FLIT_WIDTH = 32,
  parameter int CHANNELS   = 7
) (
  input  logic               clk,
  input  logic               rst,
  noc_vchannel_mux_if.slave  bus
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         lock_q, lock_d;
  logic [CW-1:0]         ptr_q, ptr_d;
  logic [CW-1:0]         chan_q, chan_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [FLIT_WIDTH-1:0] flit_q, flit_d;

  logic [CW-1:0] sel;
  logic          selected, drain, can_load, xfer;
  int            idx;

  assign drain    = valid_q & bus.out_ready[chan_q];
  assign can_load = ~valid_q | drain;
  assign xfer     = |(bus.in_valid & bus.in_ready);

  // Round-robin scan starts one past the channel that last completed a packet.
  always_comb begin
    sel      = lock_q;
    selected = 1'b0;
    idx      = 0;
    if (state_q == LOCKED) begin
      selected = 1'b1;
    end else begin
      for (int k = 1; k <= CHANNELS; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (!selected && bus.in_valid[idx]) begin
          selected = 1'b1;
          sel      = CW'(idx);
        end
      end
    end
  end

  // Reset gates ready so nothing is accepted while the adapter is still held in reset.
  always_comb begin
    bus.in_ready = '0;
    if (rst && can_load && selected) bus.in_ready[sel] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    chan_d  = chan_q;
    flit_d  = flit_q;
    last_d  = last_q;
    if (xfer) begin
      valid_d = 1'b1;
      chan_d  = sel;
      flit_d  = bus.in_flit[sel];
      last_d  = bus.in_last[sel];
      if (bus.in_last[sel]) begin
        state_d = IDLE;
        ptr_d   = sel;
      end else begin
        state_d = LOCKED;
        lock_d  = sel;
      end
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lock_q  <= '0;
      ptr_q   <= CW'(CHANNELS - 1);
      valid_q <= 1'b0;
      chan_q  <= '0;
      flit_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      chan_q  <= chan_d;
      flit_q  <= flit_d;
      last_q  <= last_d;
    end
  end

  assign bus.out_valid = valid_q ? (CHANNELS'(1) << chan_q) : '0;
  assign bus.out_flit  = flit_q;
  assign bus.out_last  = last_q;

  // Upstream must not change a flit it is offering until it has been taken.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_hold
    a_hold: assert property (@(posedge clk) disable iff (!rst)
      (bus.in_valid[c] && !bus.in_ready[c]) |=>
        (!bus.in_valid[c] || ($stable(bus.in_flit[c]) && $stable(bus.in_last[c]))));
  end
endmodule

// File: tb/tb_noc_vchannel_mux.sv
// Randomised and directed bench for noc_vchannel_mux with per-channel scoreboard queues.
module tb_noc_vchannel_mux;
  localparam int FW = 32;
  localparam int CH = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  noc_vchannel_mux_if #(.FLIT_WIDTH(FW), .CHANNELS(CH)) bus();
  noc_vchannel_mux #(.FLIT_WIDTH(FW), .CHANNELS(CH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [FW-1:0] d;
    logic          l;
    int            gap;
  } flit_t;

  flit_t       src_q[CH][$];
  flit_t       exp_q[CH][$];
  logic [CH-1:0] presenting;
  logic [CH-1:0] acc = '0;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          log_ch[$];
  int          log_cyc[$];
  logic [27:0] seq = '0;

  // reference-model state
  bit            m_locked;
  int            m_lock, m_ptr;
  bit            pend_v, stall_prev, in_pkt;
  int            pend_ch, pkt_ch;
  logic [FW-1:0] pend_d, prev_f;
  logic          pend_l;
  logic [CH-1:0] prev_ov;

  task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_flit(input int c, input logic [FW-1:0] d, input logic l, input int gap);
    flit_t f;
    f.d = d; f.l = l; f.gap = gap;
    src_q[c].push_back(f);
    exp_q[c].push_back(f);
  endtask

  task automatic push_pkt(input int c, input int len, input int gap);
    for (int i = 0; i < len; i++) begin
      push_flit(c, {c[3:0], seq}, (i == len - 1), gap);
      seq++;
    end
  endtask

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int c = 0; c < CH; c++)
      if (src_q[c].size() != 0 || exp_q[c].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic wait_idle(input int bound, input string name);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
      done = all_empty() && (bus.out_valid == '0);
    end
    chk({name, "_drain"}, done, 64'(n), 64'(bound));
  endtask

  task automatic clear_all();
    for (int c = 0; c < CH; c++) begin
      src_q[c].delete();
      exp_q[c].delete();
    end
    log_ch.delete();
    log_cyc.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b0;
    clear_all();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
  endtask

  // Adapter model: offers the head of each channel queue, honouring per-flit gaps.
  initial begin
    flit_t f;
    bus.in_valid = '0;
    bus.in_flit  = '0;
    bus.in_last  = '0;
    presenting   = '0;
    forever begin
      @(posedge clk); #1;
      for (int c = 0; c < CH; c++) begin
        if (!rst) begin
          presenting[c] = (src_q[c].size() > 0);
        end else begin
          if (acc[c] && presenting[c]) begin
            void'(src_q[c].pop_front());
            presenting[c] = 1'b0;
          end
          if (!presenting[c] && src_q[c].size() > 0) begin
            f = src_q[c][0];
            if (f.gap > 0) begin
              f.gap--;
              src_q[c][0] = f;
            end else begin
              presenting[c] = 1'b1;
            end
          end
        end
        bus.in_valid[c] = presenting[c];
        bus.in_flit[c]  = '0;
        bus.in_last[c]  = 1'b0;
        if (presenting[c]) begin
          f = src_q[c][0];
          bus.in_flit[c] = f.d;
          bus.in_last[c] = f.l;
        end
      end
    end
  end

  // Monitor: samples mid-cycle, checks link output against scoreboard and the grant rules.
  initial begin
    logic [CH-1:0] ov, xf, expx, e1;
    bit beat, can_load;
    int ch, id;
    flit_t e;
    forever begin
      @(negedge clk);
      acc = '0;
      if (!rst) begin
        m_locked = 1'b0; m_ptr = CH - 1; pend_v = 1'b0; stall_prev = 1'b0; in_pkt = 1'b0;
        continue;
      end
      cyc++;
      ov   = bus.out_valid;
      beat = (ov & bus.out_ready) != '0;
      chk("out_valid_onehot", $onehot0(ov), 64'(ov), 64'(ov));
      chk("in_ready_onehot", $onehot0(bus.in_ready), 64'(bus.in_ready), 64'(0));
      if (pend_v) begin
        e1 = CH'(1) << pend_ch;
        chk("latency", ov == e1 && bus.out_flit == pend_d && bus.out_last == pend_l,
            {ov, bus.out_last, bus.out_flit}, {e1, pend_l, pend_d});
      end
      if (stall_prev)
        chk("stall_hold", ov == prev_ov && bus.out_flit == prev_f,
            {ov, bus.out_flit}, {prev_ov, prev_f});
      if (ov != '0 && !beat)
        chk("stall_in_ready", bus.in_ready == '0, 64'(bus.in_ready), 64'(0));
      stall_prev = (ov != '0) && !beat;
      prev_ov    = ov;
      prev_f     = bus.out_flit;
      if (beat) begin
        ch = 0;
        for (int c = 0; c < CH; c++) if (ov[c]) ch = c;
        chk("sb_nonempty", exp_q[ch].size() > 0, 64'(ch), 64'(ch));
        if (exp_q[ch].size() > 0) begin
          e = exp_q[ch].pop_front();
          chk("sb_data", bus.out_flit == e.d && bus.out_last == e.l,
              {bus.out_last, bus.out_flit}, {e.l, e.d});
        end
        if (in_pkt) chk("contiguous", ch == pkt_ch, 64'(ch), 64'(pkt_ch));
        in_pkt = !bus.out_last;
        pkt_ch = ch;
        log_ch.push_back(ch);
        log_cyc.push_back(cyc);
      end
      xf       = bus.in_valid & bus.in_ready;
      can_load = (ov == '0) || beat;
      expx     = '0;
      if (can_load) begin
        if (m_locked) begin
          if (bus.in_valid[m_lock]) expx[m_lock] = 1'b1;
        end else begin
          for (int k = 1; k <= CH; k++) begin
            id = (m_ptr + k) % CH;
            if (bus.in_valid[id]) begin
              expx[id] = 1'b1;
              break;
            end
          end
        end
      end
      chk("grant", xf == expx, 64'(xf), 64'(expx));
      pend_v = 1'b0;
      for (int c = 0; c < CH; c++) begin
        if (xf[c]) begin
          pend_v = 1'b1; pend_ch = c; pend_d = bus.in_flit[c]; pend_l = bus.in_last[c];
          if (bus.in_last[c]) begin
            m_locked = 1'b0; m_ptr = c;
          end else begin
            m_locked = 1'b1; m_lock = c;
          end
        end
      end
      acc = xf;
    end
  end

  initial begin
    int exp_rr[6];
    int exp_vc[5];
    int v;
    int n;
    logic [27:0] s0;
    exp_rr = '{0, 3, 6, 0, 3, 6};
    exp_vc = '{1, 1, 1, 1, 5};
    bus.out_ready = '0;

    // reset state while channel 2 is already offering
    push_flit(2, 32'hA0, 1'b0, 0);
    push_flit(2, 32'hA1, 1'b0, 0);
    push_flit(2, 32'hA2, 1'b1, 0);
    repeat (3) @(posedge clk);
    #3;
    chk("rst_out_valid", bus.out_valid == '0, 64'(bus.out_valid), 64'(0));
    chk("rst_out_last", bus.out_last == 1'b0, 64'(bus.out_last), 64'(0));
    chk("rst_out_flit", bus.out_flit == '0, 64'(bus.out_flit), 64'(0));
    chk("rst_in_ready", bus.in_ready == '0, 64'(bus.in_ready), 64'(0));
    bus.out_ready = '1;
    rst = 1'b1;
    wait_idle(50, "single");
    chk("single_count", log_ch.size() == 3, 64'(log_ch.size()), 64'(3));
    for (int i = 0; i < 3; i++) begin
      v = (log_ch.size() > i) ? log_ch[i] : -1;
      chk("single_chan", v == 2, 64'(v), 64'(2));
    end
    for (int i = 0; i + 1 < log_cyc.size(); i++)
      chk("single_b2b", log_cyc[i+1] == log_cyc[i] + 1, 64'(log_cyc[i+1]), 64'(log_cyc[i] + 1));

    // round robin over 0,3,6
    do_reset();
    for (int r = 0; r < 2; r++) begin
      push_pkt(0, 1, 0); push_pkt(3, 1, 0); push_pkt(6, 1, 0);
    end
    wait_idle(50, "rr");
    for (int i = 0; i < 6; i++) begin
      v = (log_ch.size() > i) ? log_ch[i] : -1;
      chk("rr_order", v == exp_rr[i], 64'(v), 64'(exp_rr[i]));
    end

    // packet lock with a bubble on ch1 while ch5 waits
    do_reset();
    push_flit(1, 32'hB0, 1'b0, 0);
    push_flit(1, 32'hB1, 1'b0, 0);
    push_flit(1, 32'hB2, 1'b0, 2);
    push_flit(1, 32'hB3, 1'b1, 0);
    push_flit(5, 32'hC0, 1'b1, 0);
    wait_idle(50, "lock");
    for (int i = 0; i < 5; i++) begin
      v = (log_ch.size() > i) ? log_ch[i] : -1;
      chk("lock_order", v == exp_vc[i], 64'(v), 64'(exp_vc[i]));
    end

    // backpressure: hold the first flit for several cycles
    bus.out_ready = '0;
    do_reset();
    s0 = seq;
    push_pkt(0, 3, 0);
    repeat (7) @(posedge clk);
    #3;
    chk("bp_valid", bus.out_valid == 7'b0000001, 64'(bus.out_valid), 64'(1));
    chk("bp_flit", bus.out_flit == {4'h0, s0}, 64'(bus.out_flit), 64'({4'h0, s0}));
    chk("bp_no_beat", log_ch.size() == 0, 64'(log_ch.size()), 64'(0));
    bus.out_ready = '1;
    wait_idle(50, "bp");
    chk("bp_count", log_ch.size() == 3, 64'(log_ch.size()), 64'(3));
    for (int i = 0; i + 1 < log_cyc.size(); i++)
      chk("bp_b2b", log_cyc[i+1] == log_cyc[i] + 1, 64'(log_cyc[i+1]), 64'(log_cyc[i] + 1));

    // reset mid-packet on channel 4
    do_reset();
    push_pkt(4, 4, 0);
    n = 0;
    while (log_ch.size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("midpkt_reach", log_ch.size() >= 2, 64'(log_ch.size()), 64'(2));
    @(posedge clk); #3;
    chk("midpkt_pre_valid", bus.out_valid == 7'b0010000, 64'(bus.out_valid), 64'(7'b0010000));
    rst = 1'b0;
    #1;
    chk("midpkt_async_valid", bus.out_valid == '0, 64'(bus.out_valid), 64'(0));
    clear_all();
    push_pkt(4, 1, 0);
    push_pkt(0, 1, 0);
    repeat (2) @(posedge clk);
    #3;
    chk("midpkt_rst_ready", bus.in_ready == '0, 64'(bus.in_ready), 64'(0));
    rst = 1'b1;
    wait_idle(50, "midpkt");
    v = (log_ch.size() > 0) ? log_ch[0] : -1;
    chk("midpkt_first", v == 0, 64'(v), 64'(0));

    // random traffic with random backpressure
    do_reset();
    n = 0;
    for (int t = 0; t < 10000; t++) begin
      @(posedge clk); #3;
      for (int c = 0; c < CH; c++) begin
        bus.out_ready[c] = ($urandom_range(3) != 0);
        if (src_q[c].size() < 3 && $urandom_range(3) == 0) begin
          v = 1 + $urandom_range(3);
          push_pkt(c, v, $urandom_range(2));
          n += v;
        end
      end
    end
    @(posedge clk); #3;
    bus.out_ready = '1;
    wait_idle(2000, "random");
    chk("random_count", log_ch.size() == n, 64'(log_ch.size()), 64'(n));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
